mdu: RTL and testbench

Multiply/divide unit in the E stage of the P7 five-stage MIPS pipeline. Consumes `start` and the 4-bit `MDCtrl` produced by the control unit, computes signed/unsigned products and quotients over a fixed multi-cycle latency, owns the HI/LO registers, and returns HI/LO to the E-stage result mux for mfhi/mflo. The hazard unit stalls D whenever `start | busy` is high and the D-stage instruction is an MD-class instruction.

---
 rtl/mdu.sv | 177 +++++++++++++++++
 tb/tb_mdu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage of the pipeline.
// Define MDU_MADD_EN to decode madd/maddu/msub/msubu (MDCtrl 1000-1011).
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDCtrl,
   input  logic        req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDOut
);

   localparam logic [3:0] OP_MULT  = 4'b0000;
   localparam logic [3:0] OP_MULTU = 4'b0001;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0011;
   localparam logic [3:0] OP_MFHI  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0110;
   localparam logic [3:0] OP_MTLO  = 4'b0111;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'b1000;
   localparam logic [3:0] OP_MADDU = 4'b1001;
   localparam logic [3:0] OP_MSUB  = 4'b1010;
   localparam logic [3:0] OP_MSUBU = 4'b1011;
`endif

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] hi_t, lo_t, hi_t_next, lo_t_next;
   logic [31:0] hi_next, lo_next;

   // Shared arithmetic datapath; results are captured once at start.
   logic [63:0] prod_s, prod_u;
   logic        div_signed;
   logic [31:0] div_a, div_b, q_raw, r_raw, quot, rem;

   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'b0, A} * {32'b0, B};

   // One unsigned divider serves both div and divu; signed operands go in as magnitudes.
   assign div_signed = (MDCtrl == OP_DIV);
   assign div_a = (div_signed && A[31]) ? (~A + 32'd1) : A;
   always_comb begin
      div_b = (div_signed && B[31]) ? (~B + 32'd1) : B;
      if (B == 32'd0) div_b = 32'd1;
   end
   assign q_raw = div_a / div_b;
   assign r_raw = div_a % div_b;
   assign quot  = (div_signed && (A[31] ^ B[31])) ? (~q_raw + 32'd1) : q_raw;
   assign rem   = (div_signed && A[31]) ? (~r_raw + 32'd1) : r_raw;

   logic        op_valid;
   logic        op_is_div;
   logic [31:0] res_hi, res_lo;

`ifdef MDU_MADD_EN
   logic [63:0] acc;
   assign acc = {HI, LO};
`endif

   always_comb begin
      op_valid  = 1'b0;
      op_is_div = 1'b0;
      res_hi    = HI;
      res_lo    = LO;
      case (MDCtrl)
         OP_MULT: begin
            op_valid = 1'b1;
            {res_hi, res_lo} = prod_s;
         end
         OP_MULTU: begin
            op_valid = 1'b1;
            {res_hi, res_lo} = prod_u;
         end
         OP_DIV, OP_DIVU: begin
            op_valid  = 1'b1;
            op_is_div = 1'b1;
            // Divide by zero keeps the architectural HI/LO but still burns the full latency.
            if (B != 32'd0) begin
               res_hi = rem;
               res_lo = quot;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            op_valid = 1'b1;
            {res_hi, res_lo} = acc + prod_s;
         end
         OP_MADDU: begin
            op_valid = 1'b1;
            {res_hi, res_lo} = acc + prod_u;
         end
         OP_MSUB: begin
            op_valid = 1'b1;
            {res_hi, res_lo} = acc - prod_s;
         end
         OP_MSUBU: begin
            op_valid = 1'b1;
            {res_hi, res_lo} = acc - prod_u;
         end
`endif
         default: begin
            op_valid = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      hi_t_next  = hi_t;
      lo_t_next  = lo_t;
      hi_next    = HI;
      lo_next    = LO;
      case (state)
         IDLE: begin
            if (start && !req && op_valid) begin
               hi_t_next  = res_hi;
               lo_t_next  = res_lo;
               cnt_next   = op_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
               state_next = BUSY;
            end else if (!start && !req) begin
               if (MDCtrl == OP_MTHI) hi_next = A;
               if (MDCtrl == OP_MTLO) lo_next = A;
            end
         end
         BUSY: begin
            // New starts and mt writes are ignored here; the pending result commits on the last count.
            if (cnt <= 4'd1) begin
               hi_next    = hi_t;
               lo_next    = lo_t;
               cnt_next   = 4'd0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         hi_t  <= 32'd0;
         lo_t  <= 32'd0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         hi_t  <= hi_t_next;
         lo_t  <= lo_t_next;
         HI    <= hi_next;
         LO    <= lo_next;
      end
   end

   assign busy  = (state == BUSY);
   assign MDOut = (MDCtrl == OP_MFHI) ? HI : LO;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: arithmetic results, busy timing, req/busy suppression,
// mt writes, optional madd family (MDU_MADD_EN) and mid-operation reset.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  MDCtrl;
   logic        req;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDOut;

   int tests = 0;
   int fails = 0;

   mdu dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .MDCtrl (MDCtrl),
      .req    (req),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO),
      .MDOut  (MDOut)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
      chk({tag, "_hi"}, HI, hi_exp);
      chk({tag, "_lo"}, LO, lo_exp);
   endtask

   // Launch one op and check busy is low on the start cycle, high for n cycles, then low.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n);
      MDCtrl = op;
      A      = a;
      B      = b;
      start  = 1'b1;
      #1;
      chk({tag, "_start_busy"}, {31'b0, busy}, 32'd0);
      tick();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
         tick();
      end
      chk({tag, "_done"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      MDCtrl = 4'b0000;
      req    = 1'b0;
      A      = 32'd0;
      B      = 32'd0;
      tick();
      tick();
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk_hilo("reset", 32'd0, 32'd0);
      reset = 1'b1;
      tick();

      run_op("mult", 4'b0000, 32'hFFFF_FFFE, 32'd3, 5);
      chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      run_op("multu", 4'b0001, 32'hFFFF_FFFE, 32'd3, 5);
      chk_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

      run_op("div", 4'b0010, 32'hFFFF_FFF9, 32'd2, 10);
      chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op("divu_zero", 4'b0011, 32'd7, 32'd0, 10);
      chk_hilo("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op("divu", 4'b0011, 32'd100, 32'd7, 10);
      chk_hilo("divu", 32'd2, 32'd14);

      MDCtrl = 4'b0100;
      #1;
      chk("mfhi_out", MDOut, 32'd2);
      MDCtrl = 4'b0101;
      #1;
      chk("mflo_out", MDOut, 32'd14);

      MDCtrl = 4'b0110;
      A      = 32'h1234_5678;
      tick();
      MDCtrl = 4'b0101;
      #1;
      chk("mthi_mflo", MDOut, 32'd14);
      MDCtrl = 4'b0100;
      #1;
      chk("mthi_mfhi", MDOut, 32'h1234_5678);

      MDCtrl = 4'b0111;
      A      = 32'hDEAD_BEEF;
      req    = 1'b1;
      tick();
      req = 1'b0;
      MDCtrl = 4'b0000;
      chk_hilo("mtlo_req", 32'h1234_5678, 32'd14);

      MDCtrl = 4'b0000;
      A      = 32'd2;
      B      = 32'd3;
      start  = 1'b1;
      req    = 1'b1;
      tick();
      start = 1'b0;
      req   = 1'b0;
      chk("start_req_busy", {31'b0, busy}, 32'd0);
      tick();
      chk_hilo("start_req", 32'h1234_5678, 32'd14);

      MDCtrl = 4'b0000;
      A      = 32'd3;
      B      = 32'd4;
      start  = 1'b1;
      tick();
      chk("busy_ign_c1", {31'b0, busy}, 32'd1);
      MDCtrl = 4'b0010;
      A      = 32'd100;
      B      = 32'd3;
      tick();
      chk("busy_ign_c2", {31'b0, busy}, 32'd1);
      start  = 1'b0;
      MDCtrl = 4'b0110;
      A      = 32'h0000_0055;
      tick();
      chk("busy_ign_c3", {31'b0, busy}, 32'd1);
      chk_hilo("busy_ign_old", 32'h1234_5678, 32'd14);
      MDCtrl = 4'b0000;
      tick();
      chk("busy_ign_c4", {31'b0, busy}, 32'd1);
      tick();
      chk("busy_ign_c5", {31'b0, busy}, 32'd1);
      tick();
      chk("busy_ign_end", {31'b0, busy}, 32'd0);
      chk_hilo("busy_ign", 32'd0, 32'd12);
      tick();
      chk("busy_ign_nolaunch", {31'b0, busy}, 32'd0);

      MDCtrl = 4'b0110;
      A      = 32'd99;
      start  = 1'b1;
      tick();
      start = 1'b0;
      MDCtrl = 4'b0000;
      chk("bad_op_busy", {31'b0, busy}, 32'd0);
      chk_hilo("bad_op", 32'd0, 32'd12);

      MDCtrl = 4'b0111;
      A      = 32'hFFFF_FFFF;
      tick();
      chk_hilo("mtlo", 32'd0, 32'hFFFF_FFFF);

`ifdef MDU_MADD_EN
      run_op("madd", 4'b1000, 32'd1, 32'd1, 5);
      chk_hilo("madd", 32'd1, 32'd0);
      run_op("msubu", 4'b1011, 32'd1, 32'd1, 5);
      chk_hilo("msubu", 32'd0, 32'hFFFF_FFFF);
`else
      MDCtrl = 4'b1000;
      A      = 32'd1;
      B      = 32'd1;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      MDCtrl = 4'b0000;
      chk("madd_off_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk_hilo("madd_off", 32'd0, 32'hFFFF_FFFF);
`endif

      MDCtrl = 4'b0010;
      A      = 32'd100;
      B      = 32'd7;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_mid_busy4", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk_hilo("rst_mid", 32'd0, 32'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("rst_late_busy", {31'b0, busy}, 32'd0);
      chk_hilo("rst_late", 32'd0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
